// File: rtl/stack_seq.sv
// stack_seq - multi-cycle sequencer for the PUSH rp / POP rp / CALL / RET
// stack instructions.
//
// The CPU control FSM pulses start with op/rp while this block is idle, then
// waits for done. The sequencer drives the register file's single read port,
// its write port, its write enable, and its ext (INC/DEC/INC2) pair
// adjust. It also runs a byte-wide memory request/ready handshake. Memory
// addresses come from SP through the internal address register mar.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start, op, rp   request: op 00 PUSH, 01 POP, 10 CALL, 11 RET;
//                   rp 00 BC, 01 DE, 10 HL, 11 WZ (PUSH/POP only)
//   busy            high in every state except IDLE
//   done, err       one-cycle completion pulse; err marks a memory timeout
//   rf_rd_sel       register-file read selector (rf_rdata is combinational)
//   rf_wr_sel       register-file write selector, also the ext target pair
//   rf_ext          00 none, 01 INC, 10 DEC, 11 INC2
//   rf_we, rf_wdata register-file write
//   mem_addr        byte address (always mar)
//   mem_wdata       write data, mem_we / mem_re request strobes
//   mem_rdata       read data, valid with mem_ready
//   mem_ready       access completes this cycle
//
// Selector encoding: pair index BC=0 DE=1 HL=2 WZ=3 PC=4 (SP=5).
//   hi byte {0,idx,0}, lo byte {0,idx,1}, pair {1,idx,0}.
module stack_seq #(
  parameter logic [4:0]  SP_SEL  = 5'b11010,
  parameter logic [4:0]  PC_SEL  = 5'b11000,
  parameter logic [4:0]  WZ_SEL  = 5'b10110,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [1:0]  rp,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [4:0]  rf_rd_sel,
  output logic [4:0]  rf_wr_sel,
  output logic [1:0]  rf_ext,
  output logic        rf_we,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEC1, S_ADDR, S_WRH, S_DEC2, S_WRL,
    S_LDPC, S_RDL,  S_RDH,  S_INC2, S_DONE
  } state_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rp;
  } req_t;

  localparam logic [1:0] OP_CALL   = 2'b10;
  localparam logic [1:0] EXT_NONE  = 2'b00;
  localparam logic [1:0] EXT_DEC   = 2'b10;
  localparam logic [1:0] EXT_INC2  = 2'b11;

  // Wait counter wide enough to hold TIMEOUT-1; the access is abandoned on
  // the wait cycle that would make the count reach TIMEOUT.
  localparam int             CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  T_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  state_t         state, state_n;
  req_t           req;
  logic [15:0]    mar, mar_n;
  logic [CW-1:0]  tcnt, tcnt_n;
  logic           err_q, err_n;

  logic [2:0]     idx;
  logic [4:0]     hi_sel, lo_sel;
  logic           is_mem, timed_out;

  // CALL/RET always work on PC; PUSH/POP on the requested pair.
  assign idx       = req.op[1] ? 3'd4 : {1'b0, req.rp};
  assign hi_sel    = {1'b0, idx, 1'b0};
  assign lo_sel    = {1'b0, idx, 1'b1};
  assign is_mem    = (state == S_WRH) || (state == S_WRL) ||
                     (state == S_RDL) || (state == S_RDH);
  assign timed_out = (TIMEOUT != 0) && (tcnt == T_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      req   <= '0;
      mar   <= '0;
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      mar   <= mar_n;
      tcnt  <= tcnt_n;
      err_q <= err_n;
      if (state == S_IDLE && start) req <= {op, rp};
    end
  end

  always_comb begin
    state_n   = state;
    mar_n     = mar;
    err_n     = err_q;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    err       = 1'b0;
    rf_rd_sel = SP_SEL;
    rf_wr_sel = SP_SEL;
    rf_ext    = EXT_NONE;
    rf_we     = 1'b0;
    rf_wdata  = '0;
    mem_addr  = mar;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          // PUSH/CALL (op[0]=0) pre-decrement SP; POP/RET address first.
          state_n = op[0] ? S_ADDR : S_DEC1;
          err_n   = 1'b0;
        end
      end
      S_DEC1: begin
        rf_ext  = EXT_DEC;
        state_n = S_ADDR;
      end
      S_ADDR: begin
        // SP already reflects the DEC1 decrement on the push path.
        mar_n   = rf_rdata;
        state_n = req.op[0] ? S_RDL : S_WRH;
      end
      S_WRH: begin
        rf_rd_sel = hi_sel;
        mem_wdata = rf_rdata[7:0];
        mem_we    = 1'b1;
        if (mem_ready)      state_n = S_DEC2;
        else if (timed_out) begin state_n = S_DONE; err_n = 1'b1; end
      end
      S_DEC2: begin
        // mar tracks SP so the low byte goes to the second decremented slot.
        rf_ext  = EXT_DEC;
        mar_n   = mar - 16'd1;
        state_n = S_WRL;
      end
      S_WRL: begin
        rf_rd_sel = lo_sel;
        mem_wdata = rf_rdata[7:0];
        mem_we    = 1'b1;
        if (mem_ready)      state_n = (req.op == OP_CALL) ? S_LDPC : S_DONE;
        else if (timed_out) begin state_n = S_DONE; err_n = 1'b1; end
      end
      S_LDPC: begin
        rf_rd_sel = WZ_SEL;
        rf_wr_sel = PC_SEL;
        rf_we     = 1'b1;
        rf_wdata  = rf_rdata;
        state_n   = S_DONE;
      end
      S_RDL: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          rf_wr_sel = lo_sel;
          rf_we     = 1'b1;
          rf_wdata  = {8'h00, mem_rdata};
          mar_n     = mar + 16'd1;
          state_n   = S_RDH;
        end else if (timed_out) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_RDH: begin
        mem_re = 1'b1;
        if (mem_ready) begin
          rf_wr_sel = hi_sel;
          rf_we     = 1'b1;
          rf_wdata  = {8'h00, mem_rdata};
          state_n   = S_INC2;
        end else if (timed_out) begin
          state_n = S_DONE;
          err_n   = 1'b1;
        end
      end
      S_INC2: begin
        rf_ext  = EXT_INC2;
        state_n = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Counter restarts on every state change, so each access gets a full
    // budget; it only advances while a memory state is stalled.
    tcnt_n = (is_mem && state_n == state) ? tcnt + 1'b1 : '0;
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb_stack_seq - directed self-checking bench for stack_seq.
// It has a behavioural register file (pairs BC DE HL WZ PC SP at index 0..5)
// and a byte memory with a programmable ready delay. Both are updated on
// the clock edge from the DUT's controls. All checks are done at negedge.
module tb_stack_seq;

  localparam logic [4:0] SP_SEL = 5'b11010;
  localparam logic [1:0] OP_PUSH = 2'b00, OP_POP = 2'b01, OP_CALL = 2'b10, OP_RET = 2'b11;
  localparam int I_BC = 0, I_DE = 1, I_HL = 2, I_WZ = 3, I_PC = 4, I_SP = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00, rp = 2'b00;
  logic        busy, done, err;
  logic [4:0]  rf_rd_sel, rf_wr_sel;
  logic [1:0]  rf_ext;
  logic        rf_we;
  logic [15:0] rf_wdata, rf_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_we, mem_re, mem_ready;

  int n_tests = 0, n_fail = 0;

  stack_seq #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rp(rp),
    .busy(busy), .done(done), .err(err),
    .rf_rd_sel(rf_rd_sel), .rf_wr_sel(rf_wr_sel), .rf_ext(rf_ext),
    .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  logic [15:0] rf  [0:7];
  logic [7:0]  mem [0:65535];
  logic [15:0] rd_pair;
  int          mem_lat = 0;
  bit          mem_hang = 1'b0;
  int          req_cnt = 0;

  // Backdoor loads are applied by the model process on the next edge.
  bit          poke_rf = 1'b0, poke_mem = 1'b0;
  int          poke_idx = 0;
  logic [15:0] poke_val = '0;

  always_comb begin
    rd_pair  = rf[rf_rd_sel[3:1]];
    rf_rdata = rf_rd_sel[4] ? rd_pair
                            : {8'h00, (rf_rd_sel[0] ? rd_pair[7:0] : rd_pair[15:8])};
  end

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = (mem_we | mem_re) && !mem_hang && (req_cnt >= mem_lat);

  always @(posedge clk) begin
    if ((mem_we | mem_re) && !mem_ready) req_cnt <= req_cnt + 1;
    else req_cnt <= 0;
    if (mem_we && mem_ready) mem[mem_addr] <= mem_wdata;
    if (rf_we) begin
      if (rf_wr_sel[4])      rf[rf_wr_sel[3:1]]       <= rf_wdata;
      else if (rf_wr_sel[0]) rf[rf_wr_sel[3:1]][7:0]  <= rf_wdata[7:0];
      else                   rf[rf_wr_sel[3:1]][15:8] <= rf_wdata[7:0];
    end
    case (rf_ext)
      2'b01:   rf[rf_wr_sel[3:1]] <= rf[rf_wr_sel[3:1]] + 16'd1;
      2'b10:   rf[rf_wr_sel[3:1]] <= rf[rf_wr_sel[3:1]] - 16'd1;
      2'b11:   rf[rf_wr_sel[3:1]] <= rf[rf_wr_sel[3:1]] + 16'd2;
      default: ;
    endcase
    if (poke_rf)  rf[poke_idx[2:0]]   <= poke_val;
    if (poke_mem) mem[poke_idx[15:0]] <= poke_val[7:0];
  end

  // ---------------- monitors ----------------
  int          overlap = 0, unstable = 0, req_cycles = 0;
  bit          prev_wait = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;

  always @(negedge clk) begin
    if (rf_we && rf_ext != 2'b00) overlap++;
    if (mem_we | mem_re) req_cycles++;
    if (prev_wait && (mem_we | mem_re) &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_we !== prev_we))
      unstable++;
    prev_wait  = (mem_we | mem_re) && !mem_ready;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_we    = mem_we;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_rf(input int i, input logic [15:0] v);
    @(negedge clk); poke_rf = 1'b1; poke_idx = i; poke_val = v;
    @(negedge clk); poke_rf = 1'b0;
  endtask

  task automatic set_mem(input int a, input logic [7:0] v);
    @(negedge clk); poke_mem = 1'b1; poke_idx = a; poke_val = {8'h00, v};
    @(negedge clk); poke_mem = 1'b0;
  endtask

  // Pulse start for one cycle; lat counts cycles from the start edge to the
  // cycle in which done is seen (100 means done never came).
  task automatic run_op(input logic [1:0] o, input logic [1:0] r,
                        output int lat, output logic e);
    @(negedge clk); op = o; rp = r; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    e = err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    n_tests++; if ({busy, done, err, rf_we, mem_we, mem_re, rf_ext} !== 8'h00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000000", {busy, done, err, rf_we, mem_we, mem_re, rf_ext}); end
    n_tests++; if (rf_rd_sel !== SP_SEL || rf_wr_sel !== SP_SEL) begin
      n_fail++; $display("FAIL reset_sel: got %b/%b expected %b", rf_rd_sel, rf_wr_sel, SP_SEL); end
    n_tests++; if (mem_addr !== 16'h0000 || rf_wdata !== 16'h0000 || mem_wdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h expected 0000/0000/00", mem_addr, rf_wdata, mem_wdata); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_push();
    int lat; logic e; int ov0, rq0;
    set_rf(I_SP, 16'h1000); set_rf(I_BC, 16'h1234);
    ov0 = overlap; rq0 = req_cycles;
    run_op(OP_PUSH, 2'b00, lat, e);
    n_tests++; if (lat !== 6 || e !== 1'b0) begin
      n_fail++; $display("FAIL push_latency: got %0d err=%b expected 6 err=0", lat, e); end
    @(negedge clk);
    n_tests++; if (mem[16'h0FFF] !== 8'h12 || mem[16'h0FFE] !== 8'h34) begin
      n_fail++; $display("FAIL push_mem: got %h %h expected 12 34", mem[16'h0FFF], mem[16'h0FFE]); end
    n_tests++; if (rf[I_SP] !== 16'h0FFE) begin
      n_fail++; $display("FAIL push_sp: got %h expected 0ffe", rf[I_SP]); end
    n_tests++; if (req_cycles - rq0 !== 2 || overlap - ov0 !== 0) begin
      n_fail++; $display("FAIL push_reqs: got %0d req cycles, %0d overlaps expected 2, 0", req_cycles - rq0, overlap - ov0); end
  endtask

  task automatic test_pop();
    int lat; logic e; int ov0;
    set_rf(I_SP, 16'h0FFE); set_mem(16'h0FFE, 8'hCD); set_mem(16'h0FFF, 8'hAB);
    ov0 = overlap;
    run_op(OP_POP, 2'b10, lat, e);
    n_tests++; if (lat !== 5 || e !== 1'b0) begin
      n_fail++; $display("FAIL pop_latency: got %0d err=%b expected 5 err=0", lat, e); end
    @(negedge clk);
    n_tests++; if (rf[I_HL] !== 16'hABCD || rf[I_SP] !== 16'h1000) begin
      n_fail++; $display("FAIL pop_regs: got HL=%h SP=%h expected abcd 1000", rf[I_HL], rf[I_SP]); end
    n_tests++; if (overlap - ov0 !== 0) begin
      n_fail++; $display("FAIL pop_overlap: got %0d expected 0", overlap - ov0); end
  endtask

  task automatic test_call_ret();
    int lat; logic e;
    set_rf(I_PC, 16'h0203); set_rf(I_WZ, 16'h8000); set_rf(I_SP, 16'h2000);
    run_op(OP_CALL, 2'b00, lat, e);
    n_tests++; if (lat !== 7 || e !== 1'b0) begin
      n_fail++; $display("FAIL call_latency: got %0d err=%b expected 7 err=0", lat, e); end
    @(negedge clk);
    n_tests++; if (mem[16'h1FFF] !== 8'h02 || mem[16'h1FFE] !== 8'h03) begin
      n_fail++; $display("FAIL call_mem: got %h %h expected 02 03", mem[16'h1FFF], mem[16'h1FFE]); end
    n_tests++; if (rf[I_PC] !== 16'h8000 || rf[I_SP] !== 16'h1FFE) begin
      n_fail++; $display("FAIL call_regs: got PC=%h SP=%h expected 8000 1ffe", rf[I_PC], rf[I_SP]); end
    run_op(OP_RET, 2'b00, lat, e);
    n_tests++; if (lat !== 5 || e !== 1'b0) begin
      n_fail++; $display("FAIL ret_latency: got %0d err=%b expected 5 err=0", lat, e); end
    @(negedge clk);
    n_tests++; if (rf[I_PC] !== 16'h0203 || rf[I_SP] !== 16'h2000) begin
      n_fail++; $display("FAIL ret_regs: got PC=%h SP=%h expected 0203 2000", rf[I_PC], rf[I_SP]); end
  endtask

  task automatic test_wait_wrap();
    int lat; logic e; int us0, rq0;
    set_rf(I_SP, 16'h0000); set_rf(I_DE, 16'h5678);
    mem_lat = 3; us0 = unstable; rq0 = req_cycles;
    run_op(OP_PUSH, 2'b01, lat, e);
    n_tests++; if (lat !== 12 || e !== 1'b0) begin
      n_fail++; $display("FAIL wait_latency: got %0d err=%b expected 12 err=0", lat, e); end
    @(negedge clk); mem_lat = 0;
    n_tests++; if (mem[16'hFFFF] !== 8'h56 || mem[16'hFFFE] !== 8'h78 || rf[I_SP] !== 16'hFFFE) begin
      n_fail++; $display("FAIL wait_wrap: got %h %h SP=%h expected 56 78 fffe", mem[16'hFFFF], mem[16'hFFFE], rf[I_SP]); end
    n_tests++; if (unstable - us0 !== 0 || req_cycles - rq0 !== 8) begin
      n_fail++; $display("FAIL wait_stable: got %0d unstable, %0d req cycles expected 0, 8", unstable - us0, req_cycles - rq0); end
  endtask

  task automatic test_timeout();
    int lat; logic e; int rq0;
    set_rf(I_SP, 16'h3000);
    mem_hang = 1'b1; rq0 = req_cycles;
    run_op(OP_POP, 2'b00, lat, e);
    n_tests++; if (lat !== 6 || e !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done: got %0d err=%b expected 6 err=1", lat, e); end
    n_tests++; if (req_cycles - rq0 !== 4) begin
      n_fail++; $display("FAIL timeout_reqs: got %0d expected 4", req_cycles - rq0); end
    @(negedge clk); mem_hang = 1'b0;
    n_tests++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_pulse: got done=%b err=%b busy=%b expected 0 0 0", done, err, busy); end
    n_tests++; if (rf[I_SP] !== 16'h3000) begin
      n_fail++; $display("FAIL timeout_sp: got %h expected 3000", rf[I_SP]); end
  endtask

  task automatic test_back_to_back();
    int lat; logic e;
    set_rf(I_SP, 16'h4000); set_rf(I_BC, 16'h1234);
    @(negedge clk); op = OP_PUSH; rp = 2'b00; start = 1'b1;
    @(negedge clk); start = 1'b0; lat = 1;
    @(negedge clk); lat++; op = OP_POP; rp = 2'b10; start = 1'b1;
    @(negedge clk); lat++; start = 1'b0; op = OP_PUSH; rp = 2'b00;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    e = err;
    n_tests++; if (lat !== 6 || e !== 1'b0) begin
      n_fail++; $display("FAIL b2b_latency: got %0d err=%b expected 6 err=0", lat, e); end
    @(negedge clk); @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
    n_tests++; if (mem[16'h3FFF] !== 8'h12 || mem[16'h3FFE] !== 8'h34 || rf[I_SP] !== 16'h3FFE) begin
      n_fail++; $display("FAIL b2b_result: got %h %h SP=%h expected 12 34 3ffe", mem[16'h3FFF], mem[16'h3FFE], rf[I_SP]); end
  endtask

  task automatic test_reset_mid();
    int lat, n; logic e;
    set_rf(I_SP, 16'h5000); set_rf(I_DE, 16'h9ABC);
    mem_hang = 1'b1;
    @(negedge clk); op = OP_PUSH; rp = 2'b01; start = 1'b1;
    @(negedge clk); start = 1'b0; n = 0;
    while (!mem_we && n < 20) begin @(negedge clk); n++; end
    n_tests++; if (mem_we !== 1'b1 || mem_addr !== 16'h4FFF) begin
      n_fail++; $display("FAIL mid_wrh: got we=%b addr=%h expected 1 4fff", mem_we, mem_addr); end
    rst = 1'b1; #1;
    n_tests++; if ({busy, done, err, rf_we, mem_we, mem_re, rf_ext} !== 8'h00 || mem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL mid_reset: got ctrl=%b addr=%h expected 00000000 0000", {busy, done, err, rf_we, mem_we, mem_re, rf_ext}, mem_addr); end
    n_tests++; if (rf_rd_sel !== SP_SEL || rf_wr_sel !== SP_SEL) begin
      n_fail++; $display("FAIL mid_reset_sel: got %b/%b expected %b", rf_rd_sel, rf_wr_sel, SP_SEL); end
    @(negedge clk); rst = 1'b0; mem_hang = 1'b0;
    n_tests++; if (rf[I_SP] !== 16'h4FFF) begin
      n_fail++; $display("FAIL mid_sp: got %h expected 4fff", rf[I_SP]); end
    run_op(OP_PUSH, 2'b01, lat, e);
    n_tests++; if (lat !== 6 || e !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_latency: got %0d err=%b expected 6 err=0", lat, e); end
    @(negedge clk);
    n_tests++; if (mem[16'h4FFE] !== 8'h9A || mem[16'h4FFD] !== 8'hBC || rf[I_SP] !== 16'h4FFD) begin
      n_fail++; $display("FAIL post_reset_push: got %h %h SP=%h expected 9a bc 4ffd", mem[16'h4FFE], mem[16'h4FFD], rf[I_SP]); end
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop();
    test_call_ret();
    test_wait_wrap();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
